// File: rtl/mux_8x1.sv
// 8:1 multiplexer with a combinational output and an enable-gated capture register.
// Optional build macro MUX_8X1_PARITY_EN adds out_par, the even parity of out_q.
module mux_8x1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [2:0]       select,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_vld,
    output logic [2:0]       sel_q
`ifdef MUX_8X1_PARITY_EN
    ,
    output logic             out_par
`endif
);

    localparam int unsigned N_IN = 8;

    logic [WIDTH-1:0] data [N_IN];

    assign data[0] = in0;
    assign data[1] = in1;
    assign data[2] = in2;
    assign data[3] = in3;
    assign data[4] = in4;
    assign data[5] = in5;
    assign data[6] = in6;
    assign data[7] = in7;

    // Plain indexing so an unknown select propagates X instead of picking a default.
    assign out = data[select];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            sel_q   <= '0;
            out_vld <= 1'b0;
        end else if (en) begin
            out_q   <= out;
            sel_q   <= select;
            out_vld <= 1'b1;
        end
    end

`ifdef MUX_8X1_PARITY_EN
    // Parity is registered alongside out_q so the two always describe the same capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_par <= 1'b0;
        end else if (en) begin
            out_par <= ^out;
        end
    end
`endif

endmodule

// File: tb/tb_mux_8x1.sv
// Scoreboard bench for mux_8x1: directed vectors queue expected values, a monitor compares.
// Define MUX_8X1_PARITY_EN to exercise the parity build at WIDTH=4.
module tb_mux_8x1;

`ifdef MUX_8X1_PARITY_EN
    localparam int unsigned W = 4;
`else
    localparam int unsigned W = 1;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] din [8];
    logic [2:0]   select;
    logic         en;
    logic [W-1:0] out;
    logic [W-1:0] out_q;
    logic         out_vld;
    logic [2:0]   sel_q;
`ifdef MUX_8X1_PARITY_EN
    logic         out_par;
`endif

    typedef struct {
        string        name;
        logic [W-1:0] o;
        logic [W-1:0] q;
        logic [2:0]   s;
        logic         v;
        logic         p;
    } exp_t;

    exp_t sb [$];
    event chk;
    int   errors = 0;
    int   checks = 0;

    mux_8x1 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .in0     (din[0]),
        .in1     (din[1]),
        .in2     (din[2]),
        .in3     (din[3]),
        .in4     (din[4]),
        .in5     (din[5]),
        .in6     (din[6]),
        .in7     (din[7]),
        .select  (select),
        .en      (en),
        .out     (out),
        .out_q   (out_q),
        .out_vld (out_vld),
        .sel_q   (sel_q)
`ifdef MUX_8X1_PARITY_EN
        ,
        .out_par (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: act=%0h exp=%0h", n, f, act, exp);
        end
    endtask

    // Monitor: drains the scoreboard each time a sample point is announced.
    initial begin
        exp_t e;
        forever begin
            @(chk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, "out",     32'(out),     32'(e.o));
                cmp(e.name, "out_q",   32'(out_q),   32'(e.q));
                cmp(e.name, "sel_q",   32'(sel_q),   32'(e.s));
                cmp(e.name, "out_vld", 32'(out_vld), 32'(e.v));
`ifdef MUX_8X1_PARITY_EN
                cmp(e.name, "out_par", 32'(out_par), 32'(e.p));
`endif
            end
        end
    end

    task automatic push(input string n, input logic [W-1:0] eo, input logic [W-1:0] eq,
                        input logic [2:0] es, input logic ev);
        exp_t e;
        e.name = n;
        e.o    = eo;
        e.q    = eq;
        e.s    = es;
        e.v    = ev;
        e.p    = ^eq;
        sb.push_back(e);
        ->chk;
    endtask

    // pat bit i drives in<i>; expected values are for the 1-bit data pattern.
    task automatic step(input string n, input logic r, input logic e, input logic [2:0] s,
                        input logic [7:0] pat, input logic eo, input logic eq,
                        input logic [2:0] es, input logic ev);
        @(negedge clk);
        rst    = r;
        en     = e;
        select = s;
        for (int i = 0; i < 8; i++) din[i] = W'(pat[i]);
        #1;
        push(n, W'(eo), W'(eq), es, ev);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        select = 3'd0;
        for (int i = 0; i < 8; i++) din[i] = '0;

        step("reset",      1, 0, 3'd0, 8'b0000_0000, 0, 0, 3'd0, 0);
        step("sel5",       0, 0, 3'd5, 8'b0011_1000, 1, 0, 3'd0, 0);
        step("sel4",       0, 0, 3'd4, 8'b0011_1110, 1, 0, 3'd0, 0);
        step("sel7",       0, 0, 3'd7, 8'b1011_1110, 1, 0, 3'd0, 0);
        step("sel6",       0, 0, 3'd6, 8'b1011_1110, 0, 0, 3'd0, 0);
        step("sel2",       0, 0, 3'd2, 8'b1110_1010, 0, 0, 3'd0, 0);
        step("sel1",       0, 0, 3'd1, 8'b1110_1010, 1, 0, 3'd0, 0);
        step("in0_tog",    0, 0, 3'd1, 8'b1110_1011, 1, 0, 3'd0, 0);
        step("cap_arm",    0, 1, 3'd3, 8'b0000_1000, 1, 0, 3'd0, 0);
        step("cap",        0, 0, 3'd3, 8'b0000_0000, 0, 1, 3'd3, 1);
        step("hold",       0, 0, 3'd3, 8'b0000_0000, 0, 1, 3'd3, 1);
        step("nonsel_arm", 0, 1, 3'd3, 8'b1111_0111, 0, 1, 3'd3, 1);
        step("nonsel_cap", 0, 0, 3'd3, 8'b1111_0111, 0, 0, 3'd3, 1);
        step("simul_arm",  0, 1, 3'd6, 8'b0100_0000, 1, 0, 3'd3, 1);
        step("simul_cap",  0, 0, 3'd6, 8'b0100_0000, 1, 1, 3'd6, 1);
        step("rst_arm",    0, 1, 3'd5, 8'b0010_0000, 1, 1, 3'd6, 1);

        // Reset pulse between edges while en=1: registers clear at once, out unaffected.
        #1 rst = 1'b1;
        #1 push("rst_mid", W'(1'b1), W'(1'b0), 3'd0, 1'b0);
        #1 rst = 1'b0;

        step("post_rst",   0, 0, 3'd5, 8'b0010_0000, 1, 1, 3'd5, 1);
        step("rst_hold",   1, 1, 3'd7, 8'b1000_0000, 1, 0, 3'd0, 0);
        step("rst_vs_en",  1, 1, 3'd7, 8'b1000_0000, 1, 0, 3'd0, 0);
        step("rst_rel",    0, 0, 3'd7, 8'b1000_0000, 1, 0, 3'd0, 0);

`ifdef MUX_8X1_PARITY_EN
        @(negedge clk);
        en     = 1'b1;
        select = 3'd6;
        for (int i = 0; i < 8; i++) din[i] = '0;
        din[6] = 4'b1011;
        #1 push("par_arm", 4'b1011, 4'b0000, 3'd0, 1'b0);
        @(negedge clk);
        en = 1'b0;
        #1 push("par_cap", 4'b1011, 4'b1011, 3'd6, 1'b1);
`endif

        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: act=%0d pending exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
